// File: rtl/core_mem_responder.sv
// rtl/core_mem_responder.sv - data-port memory responder with programmable wait states
module core_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr_ena,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    output logic [31:0] r_data,
    output logic        stall,
    output logic        err,
    output logic [15:0] txn_count
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Request copy captured on acceptance; WAIT uses only these.
    logic              lat_we;
    logic [ADDR_W-1:0] lat_word;
    logic              lat_in_range;
    logic [31:0]       lat_wdata;

    logic [31:0] mem [0:DEPTH-1];
    logic [15:0] txn_cnt;

    // Live decode of the request currently on the bus.
    logic [ADDR_W-1:0] live_word;
    logic              live_in_range;
    logic              addr_lsb_unused;

    // Access actually performed at the coming edge.
    logic              acc_go;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_word;
    logic              acc_in_range;
    logic [31:0]       acc_wdata;

    assign live_word       = addr[ADDR_W+1:2];
    assign live_in_range   = (addr >> (ADDR_W + 2)) == 32'd0;
    assign addr_lsb_unused = ^addr[1:0];
    assign txn_count       = txn_cnt;

    // Next-state, wait counter, stall, and selection of live vs latched access.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall        = 1'b0;
        acc_go       = 1'b0;
        acc_we       = lat_we;
        acc_word     = lat_word;
        acc_in_range = lat_in_range;
        acc_wdata    = lat_wdata;
        case (state_q)
            IDLE: begin
                stall = req;
                if (req) begin
                    cnt_d = WAIT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: serve straight from the bus this edge.
                        acc_go       = 1'b1;
                        acc_we       = wr_ena;
                        acc_word     = live_word;
                        acc_in_range = live_in_range;
                        acc_wdata    = w_data;
                        state_d      = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    acc_go  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request fields when a transaction is accepted.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req) begin
            lat_we       <= wr_ena;
            lat_word     <= live_word;
            lat_in_range <= live_in_range;
            lat_wdata    <= w_data;
        end
    end

    // RAM write port; reset blocks a write so an aborted transaction leaves memory intact.
    always_ff @(posedge clk) begin
        if (acc_go && acc_we && acc_in_range && !reset) begin
            mem[acc_word] <= acc_wdata;
        end
    end

    // Read data, sticky range error and completed-transaction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= 32'd0;
            err     <= 1'b0;
            txn_cnt <= 16'd0;
        end else if (acc_go) begin
            txn_cnt <= txn_cnt + 16'd1;
            if (!acc_in_range) begin
                err <= 1'b1;
            end
            if (!acc_we) begin
                r_data <= acc_in_range ? mem[acc_word] : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_responder.sv
// tb/tb_core_mem_responder.sv - randomized self-checking bench for core_mem_responder
module tb_core_mem_responder;

    logic clk = 1'b0;
    logic reset = 1'b0;

    // Instance 0: zero wait states. Instance 1: default two wait states.
    logic req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wd0 = '0, rd0;
    logic st0, er0;
    logic [15:0] cnt0;
    logic req2 = 1'b0, we2 = 1'b0;
    logic [31:0] addr2 = '0, wd2 = '0, rd2;
    logic st2, er2;
    logic [15:0] cnt2;

    int passed = 0;
    int total = 0;

    // Reference model: word memory per instance, plus expected outputs.
    logic [31:0] mmem [2][256];
    bit          mval [2][256];
    int          mcnt [2];
    bit          merr [2];
    logic [31:0] mrd  [2];

    core_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .wr_ena(we0), .addr(addr0), .w_data(wd0),
        .r_data(rd0), .stall(st0), .err(er0), .txn_count(cnt0)
    );

    core_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req(req2), .wr_ena(we2), .addr(addr2), .w_data(wd2),
        .r_data(rd2), .stall(st2), .err(er2), .txn_count(cnt2)
    );

    always #5 clk = ~clk;

    function automatic int waits_of(input int s);
        return (s == 0) ? 0 : 2;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mcnt[s] = 0;
            merr[s] = 1'b0;
            mrd[s]  = 32'd0;
        end
    endtask

    task automatic model_apply(input int s, input bit we, input logic [31:0] a, input logic [31:0] d);
        bit in_range;
        int w;
        in_range = (a / 1024) == 0;
        w = int'(a[9:2]);
        mcnt[s] = (mcnt[s] + 1) % 65536;
        if (!in_range) merr[s] = 1'b1;
        if (we) begin
            if (in_range) begin
                mmem[s][w] = d;
                mval[s][w] = 1'b1;
            end
        end else begin
            mrd[s] = in_range ? mmem[s][w] : 32'd0;
        end
    endtask

    task automatic drive(input int s, input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (s == 0) begin
            req0 = r; we0 = we; addr0 = a; wd0 = d;
        end else begin
            req2 = r; we2 = we; addr2 = a; wd2 = d;
        end
    endtask

    // One transaction; returns the number of stalled cycles and the outputs seen in DONE.
    task automatic run_txn(input int s, input bit we, input logic [31:0] a, input logic [31:0] d,
                           output int cyc, output logic [31:0] rd, output logic e, output logic [15:0] c);
        @(negedge clk);
        drive(s, 1'b1, we, a, d);
        #1;
        cyc = 0;
        while (((s == 0) ? st0 : st2) === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
            drive(s, 1'b0, we, a, d);
            #1;
        end
        drive(s, 1'b0, we, a, d);
        rd = (s == 0) ? rd0 : rd2;
        e  = (s == 0) ? er0 : er2;
        c  = (s == 0) ? cnt0 : cnt2;
        model_apply(s, we, a, d);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        total++; if (rd2 !== 32'd0) $display("FAIL reset_rdata got %h want %h", rd2, 32'd0); else passed++;
        total++; if (er2 !== 1'b0) $display("FAIL reset_err got %b want 0", er2); else passed++;
        total++; if (cnt2 !== 16'd0) $display("FAIL reset_count got %h want 0000", cnt2); else passed++;
        total++; if (st2 !== 1'b0) $display("FAIL reset_stall_idle got %b want 0", st2); else passed++;
        req2 = 1'b1;
        #1;
        total++; if (st2 !== 1'b1) $display("FAIL reset_stall_follows_req got %b want 1", st2); else passed++;
        req2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        int cyc; logic [31:0] rd; logic e; logic [15:0] c;
        run_txn(1, 1'b1, 32'h10, 32'hCAFEBABE, cyc, rd, e, c);
        total++; if (cyc !== 3) $display("FAIL wr_stall_cycles got %0d want 3", cyc); else passed++;
        total++; if (c !== 16'(mcnt[1])) $display("FAIL wr_count got %h want %h", c, 16'(mcnt[1])); else passed++;
        total++; if (e !== 1'b0) $display("FAIL wr_err got %b want 0", e); else passed++;
        run_txn(1, 1'b0, 32'h10, 32'h0, cyc, rd, e, c);
        total++; if (cyc !== 3) $display("FAIL rd_stall_cycles got %0d want 3", cyc); else passed++;
        total++; if (rd !== 32'hCAFEBABE) $display("FAIL rd_data got %h want %h", rd, 32'hCAFEBABE); else passed++;
        total++; if (c !== 16'd2) $display("FAIL rd_count got %h want 0002", c); else passed++;
    endtask

    task automatic test_zero_wait();
        int cyc; logic [31:0] rd; logic e; logic [15:0] c;
        run_txn(0, 1'b1, 32'h20, 32'h12345678, cyc, rd, e, c);
        total++; if (cyc !== 1) $display("FAIL zw_wr_stall_cycles got %0d want 1", cyc); else passed++;
        run_txn(0, 1'b0, 32'h20, 32'h0, cyc, rd, e, c);
        total++; if (cyc !== 1) $display("FAIL zw_rd_stall_cycles got %0d want 1", cyc); else passed++;
        total++; if (rd !== 32'h12345678) $display("FAIL zw_rd_data got %h want %h", rd, 32'h12345678); else passed++;
        total++; if (c !== 16'(mcnt[0])) $display("FAIL zw_count got %h want %h", c, 16'(mcnt[0])); else passed++;
    endtask

    task automatic test_out_of_range();
        int cyc; logic [31:0] rd; logic e; logic [15:0] c;
        run_txn(1, 1'b1, 32'h400, 32'hDEADBEEF, cyc, rd, e, c);
        total++; if (e !== 1'b1) $display("FAIL oor_wr_err got %b want 1", e); else passed++;
        total++; if (rd !== 32'hCAFEBABE) $display("FAIL oor_wr_rdata_held got %h want %h", rd, 32'hCAFEBABE); else passed++;
        run_txn(1, 1'b0, 32'h400, 32'h0, cyc, rd, e, c);
        total++; if (rd !== 32'd0) $display("FAIL oor_rd_data got %h want 0", rd); else passed++;
        total++; if (e !== 1'b1) $display("FAIL oor_rd_err got %b want 1", e); else passed++;
        run_txn(1, 1'b0, 32'h10, 32'h0, cyc, rd, e, c);
        total++; if (rd !== 32'hCAFEBABE) $display("FAIL oor_after_rd_data got %h want %h", rd, 32'hCAFEBABE); else passed++;
        total++; if (e !== 1'b1) $display("FAIL oor_after_err got %b want 1", e); else passed++;
        total++; if (c !== 16'(mcnt[1])) $display("FAIL oor_count got %h want %h", c, 16'(mcnt[1])); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        int cyc; logic [31:0] rd; logic e; logic [15:0] c;
        run_txn(1, 1'b1, 32'h08, 32'hAAAAAAAA, cyc, rd, e, c);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h08, 32'hFFFFFFFF);
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 32'h08, 32'hFFFFFFFF);
        @(negedge clk);
        #1;
        total++; if (st2 !== 1'b1) $display("FAIL mid_wait_stall got %b want 1", st2); else passed++;
        reset = 1'b1;
        #1;
        model_reset();
        total++; if (st2 !== 1'b0) $display("FAIL mid_wait_reset_stall got %b want 0", st2); else passed++;
        total++; if (cnt2 !== 16'd0) $display("FAIL mid_wait_reset_count got %h want 0000", cnt2); else passed++;
        total++; if (er2 !== 1'b0) $display("FAIL mid_wait_reset_err got %b want 0", er2); else passed++;
        @(negedge clk);
        reset = 1'b0;
        run_txn(1, 1'b0, 32'h08, 32'h0, cyc, rd, e, c);
        total++; if (rd !== 32'hAAAAAAAA) $display("FAIL mid_wait_rd_data got %h want %h", rd, 32'hAAAAAAAA); else passed++;
        total++; if (c !== 16'd1) $display("FAIL mid_wait_count got %h want 0001", c); else passed++;
    endtask

    task automatic test_wrap();
        int cyc; logic [31:0] rd; logic e; logic [15:0] c;
        @(negedge clk);
        force dut.txn_cnt = 16'hFFFF;
        #1;
        release dut.txn_cnt;
        mcnt[1] = 65535;
        run_txn(1, 1'b0, 32'h08, 32'h0, cyc, rd, e, c);
        total++; if (c !== 16'h0000) $display("FAIL wrap_count got %h want 0000", c); else passed++;
        total++; if (c !== 16'(mcnt[1])) $display("FAIL wrap_model_count got %h want %h", c, 16'(mcnt[1])); else passed++;
    endtask

    task automatic test_random();
        int cyc; logic [31:0] rd; logic e; logic [15:0] c;
        bit we; logic [31:0] a, d; int w;
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 40; n++) begin
                we = ($urandom_range(0, 1) == 1);
                d  = $urandom;
                if ($urandom_range(0, 6) == 0) begin
                    a = $urandom;
                    if (a[31:10] == 22'd0) a[31] = 1'b1;
                end else begin
                    w = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 15);
                    a = (32'(w) << 2) | 32'($urandom_range(0, 3));
                    if (!we && !mval[s][w]) we = 1'b1;
                end
                run_txn(s, we, a, d, cyc, rd, e, c);
                total++; if (cyc !== waits_of(s) + 1) $display("FAIL rand_stall s%0d n%0d got %0d want %0d", s, n, cyc, waits_of(s) + 1); else passed++;
                total++; if (rd !== mrd[s]) $display("FAIL rand_rdata s%0d n%0d got %h want %h", s, n, rd, mrd[s]); else passed++;
                total++; if (e !== merr[s]) $display("FAIL rand_err s%0d n%0d got %b want %b", s, n, e, merr[s]); else passed++;
                total++; if (c !== 16'(mcnt[s])) $display("FAIL rand_count s%0d n%0d got %h want %h", s, n, c, 16'(mcnt[s])); else passed++;
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) begin
                mval[s][i] = 1'b0;
                mmem[s][i] = 32'd0;
            end
        end
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_write_read();
        test_zero_wait();
        test_out_of_range();
        test_reset_mid_wait();
        test_wrap();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
